// File: rtl/cpu_ctrl_seq.sv
// Fetch/execute control sequencer for the tiny CPU register datapath.
// Walks IDLE -> T1..T6 -> (T1 | HALT) and decodes the datapath strobes
// combinationally from the current T-state and the IR opcode field.
// RAM reads in T3/T5 stall on mem_ready; loads fed from RAM are masked
// while the read data is not yet valid so stale bus values are never captured.
module cpu_ctrl_seq #(
  parameter int OPW       = 4,
  parameter int CNT_W     = 8,
  parameter int EARLY_END = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             pc_inc,
  output logic             pc_oe,
  output logic             mar_load,
  output logic             ram_oe,
  output logic             ir_load,
  output logic             ir_oe,
  output logic             acc_load,
  output logic             acc_oe,
  output logic             b_load,
  output logic             alu_sub,
  output logic             alu_oe,
  output logic             out_load,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  // Short instructions return to T1 right after their last active T-state.
  localparam logic EARLY_S = (EARLY_END != 0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] count_r;

  logic is_lda_s;
  logic is_add_s;
  logic is_sub_s;
  logic is_out_s;
  logic is_hlt_s;
  logic is_nop_s;
  logic is_alu_s;
  logic is_mem5_s;

  // Opcode class decode; anything not listed behaves as a NOP.
  always_comb begin
    is_lda_s = 1'b0;
    is_add_s = 1'b0;
    is_sub_s = 1'b0;
    is_out_s = 1'b0;
    is_hlt_s = 1'b0;
    is_nop_s = 1'b0;
    case (opcode)
      OP_LDA:  is_lda_s = 1'b1;
      OP_ADD:  is_add_s = 1'b1;
      OP_SUB:  is_sub_s = 1'b1;
      OP_OUT:  is_out_s = 1'b1;
      OP_HLT:  is_hlt_s = 1'b1;
      default: is_nop_s = 1'b1;
    endcase
    is_alu_s  = is_add_s | is_sub_s;
    // Only these opcodes read RAM in T5 and therefore wait on mem_ready there.
    is_mem5_s = is_lda_s | is_alu_s;
  end

  // State register; reset returns to IDLE from anywhere, including HALT and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fetch, opcode-dependent execute length, stalls and halt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_T1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_T1: state_nxt_s = ST_T2;
      ST_T2: state_nxt_s = ST_T3;
      ST_T3: begin
        if (mem_ready) begin
          state_nxt_s = ST_T4;
        end else begin
          state_nxt_s = ST_T3;
        end
      end
      ST_T4: begin
        // T4 is always visited so the opcode is sampled even for NOP.
        if (is_hlt_s) begin
          state_nxt_s = ST_HALT;
        end else if (EARLY_S && (is_out_s || is_nop_s)) begin
          state_nxt_s = ST_T1;
        end else begin
          state_nxt_s = ST_T5;
        end
      end
      ST_T5: begin
        if (is_mem5_s && !mem_ready) begin
          state_nxt_s = ST_T5;
        end else if (EARLY_S && !is_alu_s) begin
          state_nxt_s = ST_T1;
        end else begin
          state_nxt_s = ST_T6;
        end
      end
      ST_T6:   state_nxt_s = ST_T1;
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Retired-instruction counter: one count per completed instruction fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if ((state_r == ST_T3) && mem_ready) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;

  // Strobe and status decode from the current T-state and opcode class.
  always_comb begin
    pc_inc   = 1'b0;
    pc_oe    = 1'b0;
    mar_load = 1'b0;
    ram_oe   = 1'b0;
    ir_load  = 1'b0;
    ir_oe    = 1'b0;
    acc_load = 1'b0;
    acc_oe   = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_oe   = 1'b0;
    out_load = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_T1: begin
        busy     = 1'b1;
        pc_oe    = 1'b1;
        mar_load = 1'b1;
      end
      ST_T2: begin
        busy   = 1'b1;
        pc_inc = 1'b1;
      end
      ST_T3: begin
        busy    = 1'b1;
        ram_oe  = 1'b1;
        ir_load = mem_ready;
      end
      ST_T4: begin
        busy = 1'b1;
        if (is_lda_s || is_alu_s) begin
          ir_oe    = 1'b1;
          mar_load = 1'b1;
        end else if (is_out_s) begin
          acc_oe   = 1'b1;
          out_load = 1'b1;
        end else begin
          ir_oe = 1'b0;
        end
      end
      ST_T5: begin
        busy = 1'b1;
        if (is_lda_s) begin
          ram_oe   = 1'b1;
          acc_load = mem_ready;
        end else if (is_alu_s) begin
          ram_oe = 1'b1;
          b_load = mem_ready;
        end else begin
          ram_oe = 1'b0;
        end
      end
      ST_T6: begin
        busy = 1'b1;
        if (is_alu_s) begin
          alu_oe   = 1'b1;
          acc_load = 1'b1;
          alu_sub  = is_sub_s;
        end else begin
          alu_oe = 1'b0;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: three instances (early-end, full-length, 2-bit
// counter) share stimulus and are checked every cycle against a T-state
// reference model, plus literal expectations for the directed scenarios.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       mem_ready = 1'b1;

  // strobe vector bit order: pc_inc pc_oe mar_load ram_oe ir_load ir_oe
  //                          acc_load acc_oe b_load alu_sub alu_oe out_load
  logic [2:0][11:0] stb;
  logic [2:0]       busy_w;
  logic [2:0]       halt_w;
  logic [7:0]       cnt_a;
  logic [7:0]       cnt_b;
  logic [1:0]       cnt_c;

  localparam int V_T1   = 12'h600;
  localparam int V_T2   = 12'h800;
  localparam int V_T3   = 12'h180;
  localparam int V_STL3 = 12'h100;
  localparam int V_T4M  = 12'h240;
  localparam int V_T5B  = 12'h108;
  localparam int V_T5A  = 12'h120;
  localparam int V_T6A  = 12'h022;
  localparam int V_T6S  = 12'h026;

  int n_checks = 0;
  int n_fail   = 0;

  int m_t [3];
  int m_c [3];

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.OPW(4), .CNT_W(8), .EARLY_END(1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .pc_inc(stb[0][11]), .pc_oe(stb[0][10]), .mar_load(stb[0][9]), .ram_oe(stb[0][8]),
    .ir_load(stb[0][7]), .ir_oe(stb[0][6]), .acc_load(stb[0][5]), .acc_oe(stb[0][4]),
    .b_load(stb[0][3]), .alu_sub(stb[0][2]), .alu_oe(stb[0][1]), .out_load(stb[0][0]),
    .busy(busy_w[0]), .halted(halt_w[0]), .instr_count(cnt_a)
  );

  cpu_ctrl_seq #(.OPW(4), .CNT_W(8), .EARLY_END(0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .pc_inc(stb[1][11]), .pc_oe(stb[1][10]), .mar_load(stb[1][9]), .ram_oe(stb[1][8]),
    .ir_load(stb[1][7]), .ir_oe(stb[1][6]), .acc_load(stb[1][5]), .acc_oe(stb[1][4]),
    .b_load(stb[1][3]), .alu_sub(stb[1][2]), .alu_oe(stb[1][1]), .out_load(stb[1][0]),
    .busy(busy_w[1]), .halted(halt_w[1]), .instr_count(cnt_b)
  );

  cpu_ctrl_seq #(.OPW(4), .CNT_W(2), .EARLY_END(1)) u_c2 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
    .pc_inc(stb[2][11]), .pc_oe(stb[2][10]), .mar_load(stb[2][9]), .ram_oe(stb[2][8]),
    .ir_load(stb[2][7]), .ir_oe(stb[2][6]), .acc_load(stb[2][5]), .acc_oe(stb[2][4]),
    .b_load(stb[2][3]), .alu_sub(stb[2][2]), .alu_oe(stb[2][1]), .out_load(stb[2][0]),
    .busy(busy_w[2]), .halted(halt_w[2]), .instr_count(cnt_c)
  );

  // Model: t = 0 idle, 1..6 T-states, 7 halt.
  function automatic int next_t(input int t, input bit ee, input logic st,
                                input logic [3:0] op, input logic mr);
    int  last;
    bit  memop;
    memop = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
    if (op == 4'h0)                       last = 5;
    else if (op == 4'h1 || op == 4'h2)    last = 6;
    else if (op == 4'hE || op == 4'hF)    last = 4;
    else                                  last = 3;
    if (t == 0) return st ? 1 : 0;
    if (t == 7) return 7;
    if (t == 4 && op == 4'hF) return 7;
    if ((t == 3 || (t == 5 && memop)) && !mr) return t;
    if (t == 6) return 1;
    if (ee && t >= last && t >= 4) return 1;
    return t + 1;
  endfunction

  function automatic logic [11:0] exp_strobe(input int t, input logic [3:0] op, input logic mr);
    logic [11:0] v;
    bit lda, alu, sub, outp;
    lda  = (op == 4'h0);
    alu  = (op == 4'h1) || (op == 4'h2);
    sub  = (op == 4'h2);
    outp = (op == 4'hE);
    v = 12'h000;
    case (t)
      1: begin v[10] = 1'b1; v[9] = 1'b1; end
      2: v[11] = 1'b1;
      3: begin v[8] = 1'b1; v[7] = mr; end
      4: begin
        if (lda || alu) begin v[6] = 1'b1; v[9] = 1'b1; end
        if (outp) begin v[4] = 1'b1; v[0] = 1'b1; end
      end
      5: begin
        if (lda) begin v[8] = 1'b1; v[5] = mr; end
        if (alu) begin v[8] = 1'b1; v[3] = mr; end
      end
      6: if (alu) begin v[1] = 1'b1; v[5] = 1'b1; v[2] = sub; end
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  // Reference model state, advanced on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_t[i] <= 0;
        m_c[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_t[i] <= next_t(m_t[i], (i != 1), start, opcode, mem_ready);
        if (m_t[i] == 3 && mem_ready) m_c[i] <= (m_c[i] + 1) % ((i == 2) ? 4 : 256);
      end
    end
  end

  task automatic check_model();
    logic [11:0] es;
    logic        eb, eh;
    int          ac;
    for (int i = 0; i < 3; i++) begin
      es = exp_strobe(m_t[i], opcode, mem_ready);
      eb = (m_t[i] >= 1 && m_t[i] <= 6);
      eh = (m_t[i] == 7);
      ac = (i == 0) ? int'(cnt_a) : ((i == 1) ? int'(cnt_b) : int'(cnt_c));
      n_checks++;
      if (stb[i] !== es || busy_w[i] !== eb || halt_w[i] !== eh || ac != m_c[i]) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0d: got stb=%h busy=%b halted=%b cnt=%0d, want stb=%h busy=%b halted=%b cnt=%0d",
                 i, m_t[i], stb[i], busy_w[i], halt_w[i], ac, es, eb, eh, m_c[i]);
      end
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] op, input logic mr);
    @(posedge clk);
    #1;
    start = s;
    opcode = op;
    mem_ready = mr;
    @(negedge clk);
    check_model();
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [3:0] pick_op(input int r);
    case (r % 20)
      0, 1, 2, 3:     pick_op = 4'h0;
      4, 5, 6, 7:     pick_op = 4'h1;
      8, 9, 10:       pick_op = 4'h2;
      11, 12, 13:     pick_op = 4'hE;
      14:             pick_op = 4'hF;
      15, 16:         pick_op = 4'h3;
      17:             pick_op = 4'h7;
      default:        pick_op = 4'hB;
    endcase
  endfunction

  // Watchdog: the run is loop-bounded, this only guards against a stuck simulator.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int add_seq [7];
    int nop_cnt [5];
    add_seq = '{V_T1, V_T2, V_T3, V_T4M, V_T5B, V_T6A, V_T1};
    nop_cnt = '{1, 2, 3, 0, 1};

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check_model();
    end
    check_lit("reset_strobes", int'(stb[0]), 0);
    check_lit("reset_busy", int'(busy_w), 0);
    check_lit("reset_count", int'(cnt_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD full sequence
    step(1'b1, 4'h1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 4'h1, 1'b1);
      check_lit($sformatf("add_t%0d", k + 1), int'(stb[0]), add_seq[k]);
    end
    check_lit("add_count", int'(cnt_a), 1);

    // Second ADD into T5, then async reset between edges
    repeat (4) step(1'b0, 4'h1, 1'b1);
    check_lit("add2_t5", int'(stb[0]), V_T5B);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("async_rst_strobes", int'(stb[0]), 0);
    check_lit("async_rst_busy", int'(busy_w), 0);
    check_lit("async_rst_count", int'(cnt_a), 0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 4'h1, 1'b1);
    check_lit("post_rst_idle", int'(busy_w), 0);

    // LDA: early end vs full length
    step(1'b1, 4'h0, 1'b1);
    repeat (5) step(1'b0, 4'h0, 1'b1);
    check_lit("lda_t5_ee1", int'(stb[0]), V_T5A);
    check_lit("lda_t5_ee0", int'(stb[1]), V_T5A);
    step(1'b0, 4'h0, 1'b1);
    check_lit("lda_ee1_back_t1", int'(stb[0]), V_T1);
    check_lit("lda_ee0_t6_quiet", int'(stb[1]), 0);
    check_lit("lda_ee0_t6_busy", int'(busy_w[1]), 1);
    step(1'b0, 4'h0, 1'b1);
    check_lit("lda_ee0_back_t1", int'(stb[1]), V_T1);
    hard_reset();

    // T3 stall of 3 cycles
    step(1'b1, 4'h1, 1'b1);
    step(1'b0, 4'h1, 1'b1);
    step(1'b0, 4'h1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h1, 1'b0);
      check_lit($sformatf("stall_t3_%0d", k), int'(stb[0]), V_STL3);
    end
    step(1'b0, 4'h1, 1'b1);
    check_lit("stall_release", int'(stb[0]), V_T3);
    check_lit("stall_count_before", int'(cnt_a), 0);
    step(1'b0, 4'h1, 1'b1);
    check_lit("stall_t4", int'(stb[0]), V_T4M);
    check_lit("stall_count_after", int'(cnt_a), 1);
    hard_reset();

    // SUB then HLT
    step(1'b1, 4'h2, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 4'h2, 1'b1);
      check_lit($sformatf("sub_t%0d_alu_sub", k), int'(stb[0][2]), 0);
    end
    step(1'b0, 4'h2, 1'b1);
    check_lit("sub_t6", int'(stb[0]), V_T6S);
    repeat (4) step(1'b0, 4'hF, 1'b1);
    check_lit("hlt_t4_strobes", int'(stb[0]), 0);
    check_lit("hlt_t4_busy", int'(busy_w[0]), 1);
    step(1'b0, 4'hF, 1'b1);
    check_lit("halt_flag", int'(halt_w), 3'b111);
    check_lit("halt_strobes", int'(stb[0]), 0);
    check_lit("halt_busy", int'(busy_w), 0);
    check_lit("halt_count", int'(cnt_a), 2);
    for (int k = 0; k < 10; k++) begin
      step(k[0], 4'h1, 1'b1);
      check_lit($sformatf("halt_hold_%0d", k), int'(halt_w), 3'b111);
    end
    hard_reset();

    // NOPs on the 2-bit counter
    step(1'b1, 4'h3, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'h3, 1'b1);
      if (k % 4 == 1) check_lit($sformatf("nop_t1_%0d", k), int'(stb[2]), V_T1);
      if (k % 4 == 0) check_lit($sformatf("nop_cnt_%0d", k / 4), int'(cnt_c), nop_cnt[k / 4 - 1]);
    end
    hard_reset();

    // Randomized traffic with occasional async reset pulses
    for (int n = 0; n < 3000; n++) begin
      if ((m_t[0] == 7 && m_t[1] == 7) || $urandom_range(0, 299) == 0) begin
        hard_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_model();
      end else begin
        step(($urandom_range(0, 3) == 0), pick_op(int'($urandom_range(0, 999))),
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
